// File: rtl/wifi_tx_mapper_ctrl.sv
// Frame sequencer between the WiFi TX interleaver and the constellation mapper.
// Optional inter-symbol gap on the input side: define WIFI_TX_MAPPER_CTRL_GAP_EN.
module wifi_tx_mapper_ctrl #(
    parameter int MAPPER   = 4,
    parameter int N_SD     = 48,
    parameter int WDOG_CYC = 64,
    parameter int GAP_CYC  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] n_sym,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    output logic       map_valid_in,
    output logic       map_data_in,
    input  logic       map_valid_out,
    output logic       sym_start,
    output logic       sym_end,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int NBPSC = (MAPPER == 2) ? 1 : (MAPPER == 16) ? 4 : 2;
    localparam int NCBPS = N_SD * NBPSC;
    localparam int BW    = (NCBPS > 1) ? $clog2(NCBPS) : 1;
    localparam int SW    = (N_SD > 1) ? $clog2(N_SD) : 1;
    localparam int WW    = $clog2(WDOG_CYC + 1);

    generate
        if (MAPPER != 2 && MAPPER != 4 && MAPPER != 16) begin : g_bad_mapper
            $error("wifi_tx_mapper_ctrl: MAPPER must be 2, 4 or 16");
        end
        if (GAP_CYC < 1) begin : g_bad_gap
            $error("wifi_tx_mapper_ctrl: GAP_CYC must be at least 1");
        end
    endgenerate

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAD   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef WIFI_TX_MAPPER_CTRL_GAP_EN
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam int GW = $clog2(GAP_CYC + 1);
    logic [GW-1:0] gap_cnt;
`endif

    logic [2:0]    state;
    logic [9:0]    n_sym_q;
    logic [9:0]    target;
    logic [9:0]    sym_in_cnt;
    logic [9:0]    sym_out_cnt;
    logic [BW-1:0] bit_cnt;
    logic [SW-1:0] sc_cnt;
    logic [WW-1:0] wdog;

    logic accept;
    logic bit_last;
    logic sym_last;
    logic sc_last;

    assign in_ready  = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign accept    = in_valid & in_ready;
    assign bit_last  = (bit_cnt == BW'(NCBPS - 1));
    assign sym_last  = (sym_in_cnt == n_sym_q - 10'd1);
    assign sc_last   = (sc_cnt == SW'(N_SD - 1));
    // Combinational so the markers line up with the mapper's own output strobe.
    assign sym_start = busy & map_valid_out & (sc_cnt == '0);
    assign sym_end   = busy & map_valid_out & sc_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            n_sym_q      <= '0;
            target       <= '0;
            sym_in_cnt   <= '0;
            sym_out_cnt  <= '0;
            bit_cnt      <= '0;
            sc_cnt       <= '0;
            wdog         <= '0;
            err          <= 1'b0;
            map_valid_in <= 1'b0;
            map_data_in  <= 1'b0;
`ifdef WIFI_TX_MAPPER_CTRL_GAP_EN
            gap_cnt      <= '0;
`endif
        end else begin
            map_valid_in <= accept | (state == S_PAD);
            map_data_in  <= accept & in_data;

            if (busy && map_valid_out) begin
                if (sc_last) begin
                    sc_cnt      <= '0;
                    sym_out_cnt <= sym_out_cnt + 10'd1;
                end else begin
                    sc_cnt <= sc_cnt + SW'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_sym_q     <= n_sym;
                        target      <= n_sym;
                        sym_in_cnt  <= '0;
                        sym_out_cnt <= '0;
                        bit_cnt     <= '0;
                        sc_cnt      <= '0;
                        wdog        <= '0;
                        err         <= 1'b0;
                        state       <= (n_sym == 10'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (bit_last) begin
                            bit_cnt    <= '0;
                            sym_in_cnt <= sym_in_cnt + 10'd1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    // The bit accepted alongside flush is counted before deciding whether to pad.
                    if (accept && bit_last) begin
                        if (sym_last) begin
                            state <= S_DRAIN;
                        end else if (flush) begin
                            target <= sym_in_cnt + 10'd1;
                            state  <= S_DRAIN;
                        end
`ifdef WIFI_TX_MAPPER_CTRL_GAP_EN
                        else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
`endif
                    end else if (flush) begin
                        if (!accept && bit_cnt == '0) begin
                            target <= sym_in_cnt;
                            state  <= S_DRAIN;
                        end else begin
                            target <= sym_in_cnt + 10'd1;
                            state  <= S_PAD;
                        end
                    end
                end
`ifdef WIFI_TX_MAPPER_CTRL_GAP_EN
                S_GAP: begin
                    if (flush) begin
                        target <= sym_in_cnt;
                        state  <= S_DRAIN;
                    end else if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        state <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
`endif
                S_PAD: begin
                    if (bit_last) begin
                        bit_cnt    <= '0;
                        sym_in_cnt <= sym_in_cnt + 10'd1;
                        state      <= S_DRAIN;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                S_DRAIN: begin
                    if (sym_out_cnt >= target) begin
                        state <= S_DONE;
                    end else if (map_valid_out) begin
                        wdog <= '0;
                    end else if (wdog == WW'(WDOG_CYC - 1)) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wifi_tx_mapper_ctrl.sv
// Directed bench for wifi_tx_mapper_ctrl: three instances (MAPPER 4, 16, 2) sharing
// clock and reset, each fed by its own driver and answered by a simple mapper stub.
module tb_wifi_tx_mapper_ctrl;

    typedef struct {
        int inst;
        int n_sym;
        int pat;
        int flush_at;
        bit men;
        int acc;
        int mvi;
        int pad;
        int outs;
        bit err;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [2:0] start_v;
    logic [9:0] n_sym_v [3];
    logic [2:0] flush_v;
    logic [2:0] in_valid_v;
    logic [2:0] in_data_v;
    logic [2:0] in_ready_v;
    logic [2:0] mvi_v;
    logic [2:0] mdi_v;
    logic [2:0] mvo_v;
    logic [2:0] sym_start_v;
    logic [2:0] sym_end_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] err_v;
    bit   [2:0] mapper_en;

    int total;
    int bad;
    int nbpsc [3] = '{2, 4, 1};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MP = (g == 0) ? 4 : ((g == 1) ? 16 : 2);
        wifi_tx_mapper_ctrl #(.MAPPER(MP), .N_SD(48), .WDOG_CYC(64), .GAP_CYC(16)) dut (
            .clk(clk), .reset(reset), .start(start_v[g]), .n_sym(n_sym_v[g]),
            .flush(flush_v[g]), .in_valid(in_valid_v[g]), .in_data(in_data_v[g]),
            .in_ready(in_ready_v[g]), .map_valid_in(mvi_v[g]), .map_data_in(mdi_v[g]),
            .map_valid_out(mvo_v[g]), .sym_start(sym_start_v[g]), .sym_end(sym_end_v[g]),
            .busy(busy_v[g]), .done(done_v[g]), .err(err_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mapper stub: one output strobe per NBPSC input bits, in the same cycle as the last bit.
    int bits [3];
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            mvo_v[i] = 1'b0;
            if (reset) begin
                bits[i] = 0;
            end else if (mvi_v[i]) begin
                bits[i]++;
                if (bits[i] == nbpsc[i]) begin
                    bits[i]  = 0;
                    mvo_v[i] = mapper_en[i];
                end
            end
        end
    end

    int cyc;
    int acc_cnt [3], mvi_cnt [3], pad_cnt [3], zero_err [3], lat_err [3];
    int out_cnt [3], done_cnt [3], busy_cnt [3];
    int start_cyc [3], done_cyc [3], last_mvo_cyc [3], last_acc_cyc [3], ready_fall_cyc [3];
    bit err_at_done [3];
    bit prev_acc [3], prev_data [3], prev_ready [3];
    int q_start [$];
    int q_end [$];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                prev_acc[i]   = 1'b0;
                prev_ready[i] = 1'b0;
            end else begin
                if (mvi_v[i]) begin
                    mvi_cnt[i]++;
                    if (prev_acc[i]) begin
                        if (mdi_v[i] !== prev_data[i]) lat_err[i]++;
                    end else begin
                        pad_cnt[i]++;
                        if (mdi_v[i] !== 1'b0) zero_err[i]++;
                    end
                end else begin
                    if (prev_acc[i]) lat_err[i]++;
                    if (mdi_v[i] !== 1'b0) zero_err[i]++;
                end
                if (mvo_v[i]) begin
                    out_cnt[i]++;
                    last_mvo_cyc[i] = cyc;
                    if (i == 0 && sym_start_v[0]) q_start.push_back(out_cnt[0]);
                    if (i == 0 && sym_end_v[0]) q_end.push_back(out_cnt[0]);
                end
                if (done_v[i]) begin
                    done_cnt[i]++;
                    done_cyc[i]    = cyc;
                    err_at_done[i] = err_v[i];
                end
                if (busy_v[i]) busy_cnt[i]++;
                if (start_v[i] && !busy_v[i]) start_cyc[i] = cyc;
                if (prev_ready[i] && !in_ready_v[i]) ready_fall_cyc[i] = cyc;
                if (in_valid_v[i] && in_ready_v[i]) begin
                    acc_cnt[i]++;
                    last_acc_cyc[i] = cyc;
                end
                prev_acc[i]   = in_valid_v[i] & in_ready_v[i];
                prev_data[i]  = in_data_v[i];
                prev_ready[i] = in_ready_v[i];
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Starts a frame and drives bits until done; pat 0 = continuous valid, 1 = alternating.
    task automatic applyStimulus(input int i, input int ns, input int pat, input int flush_at,
                                 output int timed_out);
        int  acc;
        logic v;
        @(posedge clk); #2;
        start_v[i]   = 1'b1;
        n_sym_v[i]   = 10'(ns);
        @(posedge clk); #2;
        start_v[i]   = 1'b0;
        acc          = 0;
        timed_out    = 1;
        for (int c = 0; c < 4000; c++) begin
            v             = (pat == 0) ? 1'b1 : ((c % 2) == 0);
            in_valid_v[i] = v;
            in_data_v[i]  = 1'($urandom_range(0, 1));
            flush_v[i]    = 1'b0;
            if (v && in_ready_v[i]) begin
                acc++;
                if (flush_at != 0 && acc == flush_at) flush_v[i] = 1'b1;
            end
            if (done_v[i]) begin
                timed_out = 0;
                break;
            end
            @(posedge clk); #2;
        end
        in_valid_v[i] = 1'b0;
        flush_v[i]    = 1'b0;
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int b_acc, b_mvi, b_pad, b_out, b_done, b_busy, b_lat, b_zero, to;
        int i;
        i            = v.inst;
        mapper_en[i] = v.men;
        b_acc  = acc_cnt[i];  b_mvi  = mvi_cnt[i];  b_pad = pad_cnt[i];
        b_out  = out_cnt[i];  b_done = done_cnt[i]; b_busy = busy_cnt[i];
        b_lat  = lat_err[i];  b_zero = zero_err[i];
        applyStimulus(i, v.n_sym, v.pat, v.flush_at, to);
        repeat (4) @(posedge clk);
        #2;
        checkOutput({tag, " done_in_budget"}, to, 0);
        checkOutput({tag, " accepts"}, acc_cnt[i] - b_acc, v.acc);
        checkOutput({tag, " map_valid_in"}, mvi_cnt[i] - b_mvi, v.mvi);
        checkOutput({tag, " pad_bits"}, pad_cnt[i] - b_pad, v.pad);
        checkOutput({tag, " pad_zero_data"}, zero_err[i] - b_zero, 0);
        checkOutput({tag, " fwd_latency"}, lat_err[i] - b_lat, 0);
        checkOutput({tag, " mapper_outputs"}, out_cnt[i] - b_out, v.outs);
        checkOutput({tag, " done_pulses"}, done_cnt[i] - b_done, 1);
        checkOutput({tag, " err"}, int'(err_at_done[i]), int'(v.err));
        if (v.acc > 0)
            checkOutput({tag, " ready_fall"}, ready_fall_cyc[i] - last_acc_cyc[i], 1);
        if (v.err)
            checkOutput({tag, " wdog_cycles"}, done_cyc[i] - ready_fall_cyc[i], 64);
        else if (v.outs > 0)
            checkOutput({tag, " done_after_last_sym"}, done_cyc[i] - last_mvo_cyc[i], 2);
        if (v.n_sym == 0) begin
            checkOutput({tag, " done_second_cycle"}, done_cyc[i] - start_cyc[i], 1);
            checkOutput({tag, " busy_cycles"}, busy_cnt[i] - b_busy, 1);
        end
    endtask

    vec_t vecs [8];
    vec_t rvec;
    int   acc;

    initial begin
        vecs[0] = '{inst: 0, n_sym: 2, pat: 0, flush_at: 0,  men: 1, acc: 192, mvi: 192, pad: 0,  outs: 96, err: 0};
        vecs[1] = '{inst: 1, n_sym: 1, pat: 1, flush_at: 0,  men: 1, acc: 192, mvi: 192, pad: 0,  outs: 48, err: 0};
        vecs[2] = '{inst: 2, n_sym: 3, pat: 0, flush_at: 30, men: 1, acc: 30,  mvi: 48,  pad: 18, outs: 48, err: 0};
        vecs[3] = '{inst: 0, n_sym: 1, pat: 0, flush_at: 0,  men: 0, acc: 96,  mvi: 96,  pad: 0,  outs: 0,  err: 1};
        vecs[4] = '{inst: 0, n_sym: 0, pat: 0, flush_at: 0,  men: 1, acc: 0,   mvi: 0,   pad: 0,  outs: 0,  err: 0};
        vecs[5] = '{inst: 2, n_sym: 2, pat: 0, flush_at: 48, men: 1, acc: 48,  mvi: 48,  pad: 0,  outs: 48, err: 0};
        vecs[6] = '{inst: 1, n_sym: 2, pat: 0, flush_at: 0,  men: 1, acc: 384, mvi: 384, pad: 0,  outs: 96, err: 0};
        vecs[7] = '{inst: 2, n_sym: 1, pat: 1, flush_at: 1,  men: 1, acc: 1,   mvi: 48,  pad: 47, outs: 48, err: 0};
        rvec    = '{inst: 0, n_sym: 1, pat: 0, flush_at: 0,  men: 1, acc: 96,  mvi: 96,  pad: 0,  outs: 48, err: 0};

        total = 0;
        bad   = 0;
        reset = 1'b1;
        start_v = '0; flush_v = '0; in_valid_v = '0; in_data_v = '0; mapper_en = '0;
        for (int i = 0; i < 3; i++) n_sym_v[i] = '0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset busy[%0d]", i), int'(busy_v[i]), 0);
            checkOutput($sformatf("reset in_ready[%0d]", i), int'(in_ready_v[i]), 0);
            checkOutput($sformatf("reset map_valid_in[%0d]", i), int'(mvi_v[i]), 0);
            checkOutput($sformatf("reset done[%0d]", i), int'(done_v[i]), 0);
            checkOutput($sformatf("reset err[%0d]", i), int'(err_v[i]), 0);
            checkOutput($sformatf("reset sym_start[%0d]", i), int'(sym_start_v[i]), 0);
        end
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            $display("[TB] vector %0d: inst %0d n_sym %0d", k, vecs[k].inst, vecs[k].n_sym);
            runVector(vecs[k], $sformatf("v%0d", k));
        end

        checkOutput("sym_start count", q_start.size(), 2);
        checkOutput("sym_start first", (q_start.size() > 0) ? q_start[0] : -1, 1);
        checkOutput("sym_start second", (q_start.size() > 1) ? q_start[1] : -1, 49);
        checkOutput("sym_end count", q_end.size(), 2);
        checkOutput("sym_end first", (q_end.size() > 0) ? q_end[0] : -1, 48);
        checkOutput("sym_end second", (q_end.size() > 1) ? q_end[1] : -1, 96);

        // Abort a frame with reset after 50 accepted bits, then run a fresh one-symbol frame.
        mapper_en[0] = 1'b1;
        @(posedge clk); #2;
        start_v[0] = 1'b1;
        n_sym_v[0] = 10'd1;
        @(posedge clk); #2;
        start_v[0] = 1'b0;
        acc = 0;
        for (int c = 0; c < 200 && acc < 50; c++) begin
            in_valid_v[0] = 1'b1;
            in_data_v[0]  = 1'($urandom_range(0, 1));
            if (in_ready_v[0]) acc++;
            @(posedge clk); #2;
        end
        checkOutput("abort pre accepts", acc, 50);
        checkOutput("abort pre busy", int'(busy_v[0]), 1);
        reset         = 1'b1;
        in_valid_v[0] = 1'b0;
        #1;
        checkOutput("abort busy", int'(busy_v[0]), 0);
        checkOutput("abort in_ready", int'(in_ready_v[0]), 0);
        checkOutput("abort map_valid_in", int'(mvi_v[0]), 0);
        checkOutput("abort map_data_in", int'(mdi_v[0]), 0);
        checkOutput("abort done", int'(done_v[0]), 0);
        checkOutput("abort err", int'(err_v[0]), 0);
        checkOutput("abort sym_start", int'(sym_start_v[0]), 0);
        checkOutput("abort sym_end", int'(sym_end_v[0]), 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        runVector(rvec, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wifi_tx_mapper_ctrl.md
Name: wifi_tx_mapper_ctrl

Overview:
- Frame-level sequencer in front of the WiFi TX constellation mapper (BPSK/QPSK/16-QAM).
- Accepts serial coded bits from the interleaver over a valid/ready handshake and forwards exactly n_sym × NCBPS bits to the mapper, where NCBPS = N_SD × NBPSC.
- Zero-pads a partial symbol on flush.
- Counts mapper outputs to mark OFDM symbol boundaries for the downstream IFFT/pilot stage, then signals frame completion or a stall error.

Parameters:
- MAPPER, 4: constellation order, one of 2, 4 or 16. NBPSC = 1, 2 or 4 respectively. Any other value is illegal (elaboration error).
- N_SD, 48: data subcarriers per OFDM symbol.
- WDOG_CYC, 64: idle cycles tolerated in DRAIN before flagging a stall.
- GAP_CYC, 16: inter-symbol idle cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start; ignored unless in IDLE.
- n_sym  in  10  OFDM symbols in the frame; sampled on start.
- flush  in  1  pad the current symbol with zeros and end the frame; honoured only in RUN.
- in_valid  in  1  upstream bit valid.
- in_data  in  1  upstream coded bit.
- in_ready  out  1  controller accepts a bit this cycle.
- map_valid_in  out  1  bit strobe to the mapper.
- map_data_in  out  1  bit to the mapper.
- map_valid_out  in  1  mapper output strobe, one per subcarrier.
- sym_start  out  1  first subcarrier of a symbol.
- sym_end  out  1  last subcarrier of a symbol.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle frame-complete pulse.
- err  out  1  stall flag.

Behaviour:
- Reset values: every output 0; state IDLE; all counters 0.
- Reset is asynchronous and may assert at any time, including mid-frame. It aborts the frame immediately. No done pulse is generated.
- States: IDLE, RUN, PAD, DRAIN, DONE.
- IDLE:
  - start with n_sym ≠ 0: latch n_sym, clear counters and err, go to RUN.
  - start with n_sym = 0: go to DONE directly; no bits are forwarded.
- in_ready = (state == RUN), registered state only; no combinational path from in_valid.
- Forwarding latency is 1 cycle: map_valid_in <= in_valid & in_ready, and map_data_in <= in_data on accept, otherwise 0.
- Input counters:
  - bit_cnt runs 0..NCBPS-1 and wraps.
  - sym_in_cnt increments on wrap.
  - Accepting the last bit of symbol n_sym-1 moves to DRAIN. in_ready is low from the next cycle.
- flush in RUN, same cycle as an accept: the accepted bit counts first.
  - If bit_cnt is then 0 (symbol boundary), go to DRAIN.
  - Otherwise go to PAD. The output target becomes sym_in_cnt+1 symbols.
- PAD: drive map_valid_in = 1, map_data_in = 0 each cycle until bit_cnt wraps, then go to DRAIN. in_ready is 0.
- Output counting is active in all non-IDLE states:
  - sc_cnt runs 0..N_SD-1 on map_valid_out and wraps.
  - sym_out_cnt increments on wrap.
  - sym_start = map_valid_out & (sc_cnt == 0); sym_end = map_valid_out & (sc_cnt == N_SD-1). Both are combinational so they align with the mapper output.
- DRAIN:
  - Go to DONE the cycle after sym_out_cnt reaches the target symbol count.
  - The watchdog counts consecutive cycles without map_valid_out and resets on each strobe. On reaching WDOG_CYC: err <= 1, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- err holds its value until the next accepted start or reset.
- map_valid_out strobes while in IDLE are ignored.

Optional Feature:
- Macro: WIFI_TX_MAPPER_CTRL_GAP_EN.
- Defined:
  - After each full input symbol except the last, RUN enters a GAP sub-state for GAP_CYC cycles with in_ready = 0, then returns to RUN.
  - flush during GAP is treated as flush at a symbol boundary (go to DRAIN).
  - The watchdog is unaffected.
- Undefined: no GAP state; RUN accepts bits continuously across symbol boundaries.

Test Plan:
- MAPPER=4, N_SD=48, start, n_sym=2, in_valid held 1 -> exactly 192 accepts and 192 map_valid_in, each 1 cycle after its accept. With the mapper responding: sym_start on outputs #1 and #49, sym_end on #48 and #96, done 1 cycle after sym_out_cnt reaches 2, err=0.
- start with n_sym=0 -> done pulses on the second cycle (via DONE); map_valid_in never asserts; busy high for 1 cycle only.
- MAPPER=16, n_sym=1, in_valid alternating 1/0 -> exactly 192 bits accepted; in_ready falls the cycle after the 192nd accept; no further map_valid_in.
- MAPPER=2, n_sym=3, flush after 30 accepted bits -> PAD issues 18 zero bits; total 48 map_valid_in; done after 48 outputs.
- DRAIN with map_valid_out held 0 -> err=1 and done pulse after 64 idle cycles; the next start clears err.
- Assert reset mid-RUN after 50 accepts -> all outputs 0 immediately. After release, a new start with n_sym=1 completes with bit_cnt starting from 0.
